// File: rtl/pixel_stream_gen_pkg.sv
// Shared timing constants, state encoding and pipeline record for pixel_stream_gen.
package pixel_stream_gen_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned CNT_W  = 13;
  localparam int unsigned ADDR_W = 19;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // Raster attributes carried alongside the frame-buffer read latency.
  typedef struct packed {
    logic             valid;
    logic             hsync;
    logic             vsync;
    logic             frame_start;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
  } pix_ctl_t;

  localparam pix_ctl_t PIX_CTL_IDLE = '{
    valid:       1'b0,
    hsync:       1'b1,
    vsync:       1'b1,
    frame_start: 1'b0,
    row:         '0,
    col:         '0
  };

endpackage

// File: rtl/pixel_stream_gen_raster_timing.sv
// Horizontal/vertical raster counters with sync and active-region decode.
module pixel_stream_gen_raster_timing
  import pixel_stream_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_first,
  output logic             frame_last
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  // Next raster position: hc wraps into vc, vc wrap returns both to the origin.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (adv) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
      end else begin
        hc_d = hc_q + CNT_W'(1);
      end
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign active      = (hc_q < H_ACT) && (vc_q < V_ACT);
  assign hsync       = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
  assign vsync       = !((vc_q >= VS_BEG) && (vc_q <= VS_END));
  assign frame_first = (hc_q == '0) && (vc_q == '0);
  assign frame_last  = (hc_q == H_LAST) && (vc_q == V_LAST);

endmodule

// File: rtl/pixel_stream_gen.sv
// Raster-scan pixel streamer: walks a frame buffer linearly and aligns timing
// outputs with the read data. Optional macro PIXEL_STREAM_GEN_TEST_PATTERN_EN
// adds tp_sel to substitute an XOR test pattern for memory data.
module pixel_stream_gen
  import pixel_stream_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
`ifdef PIXEL_STREAM_GEN_TEST_PATTERN_EN
  input  logic              tp_sel,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pix,
  output logic [CNT_W-1:0]  row,
  output logic [CNT_W-1:0]  col,
  output logic              valid,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  state_e state_q, state_d;

  logic             run;
  logic [CNT_W-1:0] hc, vc;
  logic             active, hsync_r, vsync_r, frame_first, frame_last;

  logic [ADDR_W-1:0] addr_q, addr_d;

  pix_ctl_t pipe_q [MEM_LAT];
  pix_ctl_t pipe_d [MEM_LAT];
  pix_ctl_t out_ctl;

  assign run = (state_q == ST_RUN);

  pixel_stream_gen_raster_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_raster (
    .clk         (clk),
    .rst_n       (rst_n),
    .adv         (run),
    .hc          (hc),
    .vc          (vc),
    .active      (active),
    .hsync       (hsync_r),
    .vsync       (vsync_r),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  // Stream control: start on en, stop only after the last pixel of a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (frame_last && !en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Linear read address: bumps on active pixels, holds in blanking, rewinds per frame.
  always_comb begin
    addr_d = addr_q;
    if (!run || frame_last) begin
      addr_d = '0;
    end else if (active) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Timing attributes delayed to line up with mem_rdata.
  always_comb begin
    pipe_d[0] = '{
      valid:       run & active,
      hsync:       hsync_r | ~run,
      vsync:       vsync_r | ~run,
      frame_start: run & frame_first,
      row:         vc,
      col:         hc
    };
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // State, address and alignment pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= PIX_CTL_IDLE;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign out_ctl     = pipe_q[MEM_LAT-1];
  assign mem_addr    = addr_q;
  assign row         = out_ctl.row;
  assign col         = out_ctl.col;
  assign valid       = out_ctl.valid;
  assign hsync       = out_ctl.hsync;
  assign vsync       = out_ctl.vsync;
  assign frame_start = out_ctl.frame_start;

  // Pixel source select; blanking always yields zero.
  always_comb begin
    pix = '0;
    if (out_ctl.valid) begin
`ifdef PIXEL_STREAM_GEN_TEST_PATTERN_EN
      pix = tp_sel ? (out_ctl.col[7:0] ^ out_ctl.row[7:0]) : mem_rdata;
`else
      pix = mem_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Self-checking bench: a full-size instance (first lines, resets) and a scaled
// instance (whole frames, en drop, restart) against a frame-position model.
module tb_pixel_stream_gen;

  localparam int M0 = 2;
  localparam int M1 = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic tp_sel = 1'b0;

  logic [18:0] d0_addr, d1_addr;
  logic [7:0]  d0_rdata, d1_rdata, d0_pix, d1_pix;
  logic [12:0] d0_row, d0_col, d1_row, d1_col;
  logic        d0_valid, d0_hs, d0_vs, d0_fs;
  logic        d1_valid, d1_hs, d1_vs, d1_fs;

  logic [7:0]  tbl [256];
  logic [18:0] sr0 [M0];
  logic [18:0] sr1 [M1];

  int nvec = 0;
  int nerr = 0;

  int run_m [2];
  int pos_m [2];
  int hist  [2][5];

  always #5 clk = ~clk;

  pixel_stream_gen #(.MEM_LAT(M0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef PIXEL_STREAM_GEN_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .mem_addr(d0_addr), .mem_rdata(d0_rdata), .pix(d0_pix), .row(d0_row), .col(d0_col),
    .valid(d0_valid), .hsync(d0_hs), .vsync(d0_vs), .frame_start(d0_fs)
  );

  pixel_stream_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .MEM_LAT(M1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef PIXEL_STREAM_GEN_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .mem_addr(d1_addr), .mem_rdata(d1_rdata), .pix(d1_pix), .row(d1_row), .col(d1_col),
    .valid(d1_valid), .hsync(d1_hs), .vsync(d1_vs), .frame_start(d1_fs)
  );

  // Frame-buffer models: data returns MEM_LAT clocks after the address.
  always @(posedge clk) begin
    sr0[0] <= d0_addr;
    for (int i = 1; i < M0; i++) sr0[i] <= sr0[i-1];
    sr1[0] <= d1_addr;
    for (int i = 1; i < M1; i++) sr1[i] <= sr1[i-1];
  end
  assign d0_rdata = tbl[sr0[M0-1][7:0]];
  assign d1_rdata = tbl[sr1[M1-1][7:0]];

  function automatic int ha(int k);  return (k == 0) ? 640 : 16; endfunction
  function automatic int hfp(int k); return (k == 0) ? 16  : 2;  endfunction
  function automatic int hsw(int k); return (k == 0) ? 96  : 4;  endfunction
  function automatic int hbp(int k); return (k == 0) ? 48  : 3;  endfunction
  function automatic int va(int k);  return (k == 0) ? 480 : 8;  endfunction
  function automatic int vfp(int k); return (k == 0) ? 10  : 2;  endfunction
  function automatic int vsw(int k); return (k == 0) ? 2   : 2;  endfunction
  function automatic int vbp(int k); return (k == 0) ? 33  : 3;  endfunction
  function automatic int lat(int k); return (k == 0) ? M0  : M1; endfunction
  function automatic int htot(int k); return ha(k) + hfp(k) + hsw(k) + hbp(k); endfunction
  function automatic int vtot(int k); return va(k) + vfp(k) + vsw(k) + vbp(k); endfunction

  // Address = number of active pixels strictly before frame position p.
  function automatic int addr_of(int k, int p);
    int r, c;
    r = p / htot(k);
    c = p % htot(k);
    if (r >= va(k)) return va(k) * ha(k);
    return r * ha(k) + ((c < ha(k)) ? c : ha(k));
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task model_clear();
    for (int k = 0; k < 2; k++) begin
      run_m[k] = 0;
      pos_m[k] = 0;
      for (int i = 0; i < 5; i++) hist[k][i] = -1;
    end
  endtask

  task model_edge();
    for (int k = 0; k < 2; k++) begin
      for (int i = 4; i > 0; i--) hist[k][i] = hist[k][i-1];
      if (!rst_n) begin
        run_m[k] = 0;
        pos_m[k] = 0;
      end else if (run_m[k] == 0) begin
        if (en) begin
          run_m[k] = 1;
          pos_m[k] = 0;
        end
      end else if (pos_m[k] == htot(k) * vtot(k) - 1) begin
        pos_m[k] = 0;
        run_m[k] = en ? 1 : 0;
      end else begin
        pos_m[k] = pos_m[k] + 1;
      end
      hist[k][0] = run_m[k] ? pos_m[k] : -1;
    end
  endtask

  task check_all();
    logic [18:0] oa;
    logic [7:0]  op;
    logic [12:0] orow, ocol;
    logic        ov, ohs, ovs, ofs;
    int q, r, c, ev, ep, er, ec, ehs, evs, efs;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        oa = d0_addr; op = d0_pix; orow = d0_row; ocol = d0_col;
        ov = d0_valid; ohs = d0_hs; ovs = d0_vs; ofs = d0_fs;
      end else begin
        oa = d1_addr; op = d1_pix; orow = d1_row; ocol = d1_col;
        ov = d1_valid; ohs = d1_hs; ovs = d1_vs; ofs = d1_fs;
      end
      q = hist[k][lat(k)];
      if (q < 0) begin
        ev = 0; ep = 0; er = 0; ec = 0; ehs = 1; evs = 1; efs = 0;
      end else begin
        r   = q / htot(k);
        c   = q % htot(k);
        ev  = (r < va(k) && c < ha(k)) ? 1 : 0;
        ep  = ev ? int'(tbl[(r * ha(k) + c) & 255]) : 0;
`ifdef PIXEL_STREAM_GEN_TEST_PATTERN_EN
        if (ev != 0 && tp_sel) ep = (r ^ c) & 255;
`endif
        er  = r;
        ec  = c;
        ehs = (c >= ha(k) + hfp(k) && c < ha(k) + hfp(k) + hsw(k)) ? 0 : 1;
        evs = (r >= va(k) + vfp(k) && r < va(k) + vfp(k) + vsw(k)) ? 0 : 1;
        efs = (q == 0) ? 1 : 0;
      end
      chk("mem_addr", k, 32'(oa), run_m[k] ? addr_of(k, pos_m[k]) : 0);
      chk("pix", k, 32'(op), ep);
      chk("row", k, 32'(orow), er);
      chk("col", k, 32'(ocol), ec);
      chk("valid", k, 32'(ov), ev);
      chk("hsync", k, 32'(ohs), ehs);
      chk("vsync", k, 32'(ovs), evs);
      chk("frame_start", k, 32'(ofs), efs);
    end
  endtask

  task tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task do_reset(input logic en_at_release);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all();
    ticks(3);
    en = en_at_release;
    #2;
    rst_n = 1'b1;
  endtask

  task random_segments(input int n);
    for (int s = 0; s < n; s++) begin
      en = ($urandom_range(0, 3) != 0);
      ticks($urandom_range(50, 900));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    en    = 1'b0;
    rst_n = 1'b0;
    model_clear();
    ticks(2);
    #2;
    rst_n = 1'b1;
    ticks(5);
    en = 1'b1;
    ticks(2000);
    random_segments(12);
    en = 1'b1;
    ticks(500);
    do_reset(1'b1);
    for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
    ticks(3000);
    random_segments(8);
    do_reset(1'b1);
    ticks($urandom_range(100, 600));
`ifdef PIXEL_STREAM_GEN_TEST_PATTERN_EN
    tp_sel = 1'b1;
    ticks(2000);
    tp_sel = 1'b0;
    ticks(400);
`endif
    en = 1'b0;
    ticks(1000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
